multi_var_et: RTL and testbench

- Multi-channel, parametrised successor to the single-channel variable early-termination (ET) counter.
- Tracks NCH stochastic-computing output streams in parallel. Each channel has a credit counter: it starts at nmin, is bumped by a programmable increment on every rising edge of that channel's pz, and decrements otherwise.
- The run terminates when every channel's counter reaches zero, or when an optional hard cycle limit is hit.
- Sits beside the SC datapath. It is started per evaluation through a start/done handshake and reports the cycle count at which the stream can be cut.

---
 rtl/sc_et_pkg.sv | 20 ++
 rtl/et_chan_ctr.sv | 50 +++++
 rtl/multi_var_et.sv | 111 +++++++++++
 tb/tb_multi_var_et.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/sc_et_pkg.sv
// Shared types and helpers for the multi-channel early-termination counter.
package sc_et_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } et_state_t;

  // Unsigned a+b clamped to 2^w-1; callers size-cast the result back to w bits.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/et_chan_ctr.sv
// One channel credit counter: pz rising-edge detect, saturating bump, decrement, sticky zero flag.
module et_chan_ctr
  import sc_et_pkg::*;
#(
  parameter int CTR_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [CTR_WIDTH-1:0] load_val,
  input  logic [CTR_WIDTH-1:0] inc,
  input  logic                 en,
  input  logic                 pz,
  output logic                 ctr_zero,
  output logic [CTR_WIDTH-1:0] ctr,
  output logic                 zero_nxt
);

  logic                 pz_d;
  logic                 rise;
  logic [CTR_WIDTH-1:0] ctr_nxt;

  always_comb begin
    rise    = pz & ~pz_d;
    ctr_nxt = ctr;
    // A finished channel is frozen at zero and ignores further edges.
    if (!ctr_zero) begin
      if (rise) ctr_nxt = CTR_WIDTH'(sat_add(32'(ctr), 32'(inc), CTR_WIDTH));
      else      ctr_nxt = ctr - CTR_WIDTH'(1);
    end
    zero_nxt = ctr_zero | (ctr_nxt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctr      <= '0;
      pz_d     <= 1'b0;
      ctr_zero <= 1'b0;
    end else if (load) begin
      ctr      <= load_val;
      pz_d     <= 1'b0;
      ctr_zero <= (load_val == '0);
    end else if (en) begin
      pz_d     <= pz;
      ctr      <= ctr_nxt;
      ctr_zero <= zero_nxt;
    end
  end

endmodule

// File: rtl/multi_var_et.sv
// Multi-channel variable early-termination controller: start/done handshake, per-channel
// credit counters, optional hard cycle limit; reports the cycle count at which to cut the stream.
module multi_var_et
  import sc_et_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int CTR_WIDTH = 5,
  parameter int LEN_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CTR_WIDTH-1:0] nmin,
  input  logic [CTR_WIDTH-1:0] inc,
  input  logic [LEN_WIDTH-1:0] nmax,
  input  logic [NCH-1:0]       pz,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [LEN_WIDTH-1:0] cycles,
  output logic [NCH-1:0]       ch_done
);

  et_state_t            state;
  logic [CTR_WIDTH-1:0] inc_q;
  logic [LEN_WIDTH-1:0] nmax_q;
  logic                 load;
  logic                 en;
  logic [NCH-1:0]       zero_nxt;
  logic [LEN_WIDTH-1:0] cycles_nxt;
  logic                 term_et;
  logic                 term_to;

  assign load = (state == IDLE) && start;
  assign en   = (state == RUN);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CTR_WIDTH-1:0] ctr_q;

    et_chan_ctr #(.CTR_WIDTH(CTR_WIDTH)) u_ctr (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (nmin),
      .inc      (inc_q),
      .en       (en),
      .pz       (pz[i]),
      .ctr_zero (ch_done[i]),
      .ctr      (ctr_q),
      .zero_nxt (zero_nxt[i])
    );

    // A channel flagged done must be parked at zero.
    a_done_is_zero: assert property (@(posedge clk) disable iff (rst) ch_done[i] |-> (ctr_q == '0));
  end

  assign cycles_nxt = LEN_WIDTH'(sat_add(32'(cycles), 32'd1, LEN_WIDTH));
  assign term_et    = &zero_nxt;
  assign term_to    = (nmax_q != '0) && (cycles_nxt == nmax_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
      cycles  <= '0;
      inc_q   <= '0;
      nmax_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            inc_q   <= inc;
            nmax_q  <= nmax;
            cycles  <= '0;
            timeout <= 1'b0;
            if (nmin == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          cycles <= cycles_nxt;
          // ET wins over the limit when both land on the same cycle.
          if (term_et || term_to) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= term_to & ~term_et;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_var_et.sv
// Scoreboard bench for multi_var_et (NCH=4, CTR_WIDTH=5, LEN_WIDTH=10).
module tb_multi_var_et;

  localparam int NCH = 4;

  typedef struct packed {
    logic [9:0]     cyc;
    logic           to;
    logic [NCH-1:0] chd;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [4:0]     nmin = '0;
  logic [4:0]     inc = '0;
  logic [9:0]     nmax = '0;
  logic [NCH-1:0] pz = '0;
  logic           busy, done, timeout;
  logic [9:0]     cycles;
  logic [NCH-1:0] ch_done;

  int n_chk  = 0;
  int n_fail = 0;
  exp_t           sb[$];
  logic [NCH-1:0] pat_q[$];

  always #5 clk = ~clk;

  multi_var_et dut (
    .clk(clk), .rst(rst), .start(start), .nmin(nmin), .inc(inc), .nmax(nmax), .pz(pz),
    .busy(busy), .done(done), .timeout(timeout), .cycles(cycles), .ch_done(ch_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input int nmin_v, input int inc_v, input int nmax_v,
                                 input logic [NCH-1:0] pat[$]);
    int ctr[NCH];
    logic [NCH-1:0] pzd = '0;
    logic [NCH-1:0] chd;
    logic [NCH-1:0] p;
    int cyc = 0;
    exp_t r;
    for (int c = 0; c < NCH; c++) ctr[c] = nmin_v;
    chd = (nmin_v == 0) ? '1 : '0;
    r.cyc = '0; r.to = 1'b0; r.chd = chd;
    if (nmin_v == 0) return r;
    for (int k = 0; k < 2000; k++) begin
      p = (k < pat.size()) ? pat[k] : '0;
      for (int c = 0; c < NCH; c++) begin
        if (!chd[c]) begin
          if (p[c] && !pzd[c]) ctr[c] = (ctr[c] + inc_v > 31) ? 31 : ctr[c] + inc_v;
          else                 ctr[c] = ctr[c] - 1;
          if (ctr[c] == 0) chd[c] = 1'b1;
        end
      end
      pzd = p;
      cyc = (cyc < 1023) ? cyc + 1 : 1023;
      r.cyc = 10'(cyc); r.chd = chd;
      if (&chd) begin r.to = 1'b0; return r; end
      if (nmax_v != 0 && cyc == nmax_v) begin r.to = 1'b1; return r; end
    end
    return r;
  endfunction

  // Drives one evaluation with pat_q as the per-RUN-cycle pz pattern.
  task automatic run_test(input string tag, input int nmin_v, input int inc_v, input int nmax_v,
                          input exp_t e, input int mid_k, input logic [NCH-1:0] mid_chd);
    exp_t g;
    int k;
    @(negedge clk);
    start = 1'b1; nmin = 5'(nmin_v); inc = 5'(inc_v); nmax = 10'(nmax_v); pz = '0;
    @(posedge clk); #1;
    start = 1'b0;
    sb.push_back(e);
    k = 0;
    while (!done && k < 300) begin
      if (k == mid_k) check_eq({tag, "_mid_chd"}, 32'(ch_done), 32'(mid_chd));
      check_eq({tag, "_busy"}, 32'(busy), 32'd1);
      pz = (k < pat_q.size()) ? pat_q[k] : '0;
      @(posedge clk); #1;
      k++;
    end
    g = sb.pop_front();
    if (!done) begin
      check_eq({tag, "_done_wait"}, 32'(done), 32'd1);
    end else begin
      check_eq({tag, "_latency"}, 32'(k), 32'(g.cyc));
      check_eq({tag, "_cycles"}, 32'(cycles), 32'(g.cyc));
      check_eq({tag, "_timeout"}, 32'(timeout), 32'(g.to));
      check_eq({tag, "_ch_done"}, 32'(ch_done), 32'(g.chd));
      check_eq({tag, "_busy_off"}, 32'(busy), 32'd0);
    end
    pz = '0;
    @(posedge clk); #1;
    check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  function automatic exp_t mk(input int c, input logic t, input logic [NCH-1:0] d);
    exp_t r;
    r.cyc = 10'(c); r.to = t; r.chd = d;
    return r;
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_timeout", 32'(timeout), 32'd0);
    check_eq("rst_cycles", 32'(cycles), 32'd0);
    check_eq("rst_ch_done", 32'(ch_done), 32'd0);
    @(negedge clk); rst = 1'b0;

    pat_q.delete();
    run_test("pz0", 3, 3, 0, mk(3, 1'b0, 4'hF), -1, '0);

    pat_q.delete(); pat_q.push_back(4'h0); pat_q.push_back(4'hF);
    run_test("bump", 3, 3, 0, mk(7, 1'b0, 4'hF), -1, '0);

    pat_q.delete();
    for (int i = 0; i < 40; i++) pat_q.push_back(4'hF);
    run_test("sat", 30, 3, 0, mk(32, 1'b0, 4'hF), -1, '0);

    pat_q.delete();
    run_test("limit", 20, 1, 5, mk(5, 1'b1, 4'h0), -1, '0);

    pat_q.delete();
    run_test("et_vs_limit", 3, 1, 3, mk(3, 1'b0, 4'hF), -1, '0);

    // ch1 pulses in RUN cycle 1; ch0 sees an edge in cycle 4 after it has finished.
    pat_q.delete();
    pat_q.push_back(4'b0010); pat_q.push_back(4'b0000);
    pat_q.push_back(4'b0000); pat_q.push_back(4'b0001);
    run_test("frozen", 2, 4, 0, mk(7, 1'b0, 4'hF), 2, 4'b1101);

    pat_q.delete(); pat_q.push_back(4'hF); pat_q.push_back(4'h0); pat_q.push_back(4'hF);
    run_test("inc0", 3, 0, 0, mk(5, 1'b0, 4'hF), -1, '0);

    // Reset landing in RUN cycle 3.
    @(negedge clk);
    start = 1'b1; nmin = 5'd5; inc = 5'd1; nmax = '0; pz = '0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("pre_rst_cycles", 32'(cycles), 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_done", 32'(done), 32'd0);
    check_eq("mid_rst_cycles", 32'(cycles), 32'd0);
    check_eq("mid_rst_ch_done", 32'(ch_done), 32'd0);

    pat_q.delete();
    run_test("nmin0", 0, 3, 0, mk(0, 1'b0, 4'hF), -1, '0);

    for (int t = 0; t < 4; t++) begin
      int nm, ic, nx;
      nm = $urandom_range(1, 12);
      ic = $urandom_range(0, 6);
      nx = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(5, 30);
      pat_q.delete();
      for (int i = 0; i < 40; i++) pat_q.push_back(4'($urandom_range(0, 15)));
      run_test("rand", nm, ic, nx, model(nm, ic, nx, pat_q), -1, '0);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
